// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dmem_arb_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_EXT} owner_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CORE_RD_PEND, ST_EXT_RD_PEND} state_e;
endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Saturating denial counter; flags when the external side has waited long enough.
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic          limit_hit,
  output logic [CW-1:0] cnt
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || clr)                cnt <= '0;
    else if (inc && cnt != CNT_MAX)  cnt <= cnt + 1'b1;
  end

  assign limit_hit = (cnt >= CW'(LIMIT));
endmodule

// File: rtl/dmem_arbiter.sv
// Core/external arbiter for the single-port data memory; core has priority
// except when the starvation counter forces an external slot.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic [DATA_W-1:0] core_rd_data,
  output logic              core_rd_valid,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wr_data,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rd_data,
  output logic              ext_rd_valid,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);
  state_e            state, state_nxt;
  owner_e            rd_owner;
  logic              core_req, ext_act, core_gnt, force_ext;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] core_hold, ext_hold;

  // Reset masks requests so every output sits at its reset value meanwhile.
  assign core_req  = (core_rd | core_wr) & ~reset;
  assign ext_act   = ext_req & ~reset;
  assign ext_gnt   = ext_act & (~core_req | force_ext);
  assign core_gnt  = core_req & ~ext_gnt;
  assign core_stall = core_req & ext_gnt;

  starve_counter #(.LIMIT(STARVE_LIMIT), .CW(4)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .clr       (ext_gnt | ~ext_act),
    .inc       (ext_act & ~ext_gnt),
    .limit_hit (force_ext),
    .cnt       (starve_cnt)
  );

  always_comb begin
    mem_wr      = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    rd_owner    = OWN_NONE;
    if (ext_gnt) begin
      mem_wr   = ext_we;
      mem_rd   = ~ext_we;
      mem_addr = ext_addr;
      if (ext_we) mem_wr_data = ext_wr_data;
      else        rd_owner    = OWN_EXT;
    end else if (core_gnt) begin
      // rd+wr together is illegal upstream; it resolves to a write here.
      mem_wr   = core_wr;
      mem_rd   = ~core_wr;
      mem_addr = core_addr;
      if (core_wr) mem_wr_data = core_wr_data;
      else         rd_owner    = OWN_CORE;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (rd_owner)
      OWN_CORE: state_nxt = ST_CORE_RD_PEND;
      OWN_EXT:  state_nxt = ST_EXT_RD_PEND;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  assign core_rd_valid = (state == ST_CORE_RD_PEND) & ~reset;
  assign ext_rd_valid  = (state == ST_EXT_RD_PEND) & ~reset;

  // Each side keeps its last returned word until its next read completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      core_hold <= '0;
      ext_hold  <= '0;
    end else begin
      if (core_rd_valid) core_hold <= mem_rd_data;
      if (ext_rd_valid)  ext_hold  <= mem_rd_data;
    end
  end

  assign core_rd_data = reset ? '0 : (core_rd_valid ? mem_rd_data : core_hold);
  assign ext_rd_data  = reset ? '0 : (ext_rd_valid  ? mem_rd_data : ext_hold);

  logic unused_ok;
  assign unused_ok = ^starve_cnt;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue/array model.
module tb_dmem_arbiter;
  localparam int DW = 32, AW = 9, LIM = 4;

  logic          clk = 0, reset = 1;
  logic          core_rd = 0, core_wr = 0, ext_req = 0, ext_we = 0;
  logic [AW-1:0] core_addr = '0, ext_addr = '0;
  logic [DW-1:0] core_wr_data = '0, ext_wr_data = '0;
  logic [DW-1:0] core_rd_data, ext_rd_data, mem_wr_data, mem_rd_data;
  logic          core_rd_valid, core_stall, ext_gnt, ext_rd_valid, mem_wr, mem_rd;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0, n_err = 0;

  dmem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_rd_data(core_rd_data), .core_rd_valid(core_rd_valid), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wr_data(ext_wr_data),
    .ext_gnt(ext_gnt), .ext_rd_data(ext_rd_data), .ext_rd_valid(ext_rd_valid),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Environment memory: 1-cycle read latency, driven only by the DUT's port.
  logic [DW-1:0] env_mem [512];
  initial begin
    for (int i = 0; i < 512; i++) env_mem[i] = '0;
    mem_rd_data = '0;
  end
  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= env_mem[mem_addr];
  end

  always @(negedge clk)
    assert (!(core_rd && core_wr)) else $error("illegal core_rd and core_wr together");

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: grant rule, denial count, pending read and per-side last data.
  logic [DW-1:0] ref_mem [512];
  int            m_starve = 0, m_pend = 0;
  logic [DW-1:0] m_pdata = '0, m_lcore = '0, m_lext = '0;

  initial begin
    bit creq, ereq, eg, cg;
    logic [DW-1:0] e_cdat, e_edat;
    for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      creq = (core_rd || core_wr) && !reset;
      ereq = ext_req && !reset;
      eg   = ereq && (!creq || m_starve >= LIM);
      cg   = creq && !eg;
      chk("ext_gnt",    ext_gnt, eg);
      chk("core_stall", core_stall, creq && eg);
      chk("mem_wr",     mem_wr, eg ? ext_we : (cg ? core_wr : 1'b0));
      chk("mem_rd",     mem_rd, eg ? !ext_we : (cg ? !core_wr : 1'b0));
      chk("mem_addr",   mem_addr, eg ? ext_addr : (cg ? core_addr : '0));
      chk("mem_wr_data", mem_wr_data,
          (eg && ext_we) ? ext_wr_data : ((cg && core_wr) ? core_wr_data : '0));
      e_cdat = reset ? '0 : (m_pend == 1 ? m_pdata : m_lcore);
      e_edat = reset ? '0 : (m_pend == 2 ? m_pdata : m_lext);
      chk("core_rd_valid", core_rd_valid, !reset && m_pend == 1);
      chk("ext_rd_valid",  ext_rd_valid,  !reset && m_pend == 2);
      chk("core_rd_data",  core_rd_data, e_cdat);
      chk("ext_rd_data",   ext_rd_data,  e_edat);
      @(posedge clk);
      if (reset) begin
        m_starve = 0; m_pend = 0; m_lcore = '0; m_lext = '0;
      end else begin
        if (m_pend == 1) m_lcore = m_pdata;
        if (m_pend == 2) m_lext  = m_pdata;
        m_pend = 0;
        if (eg) begin
          if (ext_we) ref_mem[ext_addr] = ext_wr_data;
          else begin m_pend = 2; m_pdata = ref_mem[ext_addr]; end
        end else if (cg) begin
          if (core_wr) ref_mem[core_addr] = core_wr_data;
          else begin m_pend = 1; m_pdata = ref_mem[core_addr]; end
        end
        m_starve = (eg || !ereq) ? 0 : ((m_starve < 15) ? m_starve + 1 : 15);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    core_rd = 0; core_wr = 0; ext_req = 0; ext_we = 0;
  endtask

  initial begin
    bit g, s;
    repeat (3) step();
    chk("rst core_rd_data", core_rd_data, '0);
    chk("rst ext_rd_valid", ext_rd_valid, 1'b0);
    reset = 0;

    // Core-only write then read.
    core_wr = 1; core_addr = 9'h010; core_wr_data = 32'hDEADBEEF; #1;
    chk("t1 wr no stall", core_stall, 1'b0);
    step(); core_wr = 0; core_rd = 1; #1;
    chk("t1 rd no stall", core_stall, 1'b0);
    step(); idle(); #1;
    chk("t1 core_rd_valid", core_rd_valid, 1'b1);
    chk("t1 core_rd_data", core_rd_data, 32'hDEADBEEF);
    chk("t1 ext_rd_valid", ext_rd_valid, 1'b0);

    // Ext-only write then read, with the core idle.
    step(); ext_req = 1; ext_we = 1; ext_addr = 9'h1FF; ext_wr_data = 32'h12345678; #1;
    chk("t2 wr gnt", ext_gnt, 1'b1);
    step(); ext_we = 0; #1;
    chk("t2 rd gnt", ext_gnt, 1'b1);
    step(); idle(); #1;
    chk("t2 ext_rd_valid", ext_rd_valid, 1'b1);
    chk("t2 ext_rd_data", ext_rd_data, 32'h12345678);

    // Contention: core reads 0x010 every cycle, ext read of 0x1FF waits.
    step();
    for (int i = 0; i < 7; i++) begin
      core_rd = (i < 6); core_addr = 9'h010;
      ext_req = (i < 5); ext_we = 0; ext_addr = 9'h1FF;
      #1;
      chk($sformatf("t3 ext_gnt c%0d", i), ext_gnt, (i == 4));
      chk($sformatf("t3 stall c%0d", i), core_stall, (i == 4));
      if (i == 4) chk("t3 core data before ext", core_rd_data, 32'hDEADBEEF);
      if (i == 5) begin
        chk("t3 ext_rd_valid", ext_rd_valid, 1'b1);
        chk("t3 ext_rd_data", ext_rd_data, 32'h12345678);
        chk("t3 no core valid", core_rd_valid, 1'b0);
      end
      if (i == 6) chk("t3 core resumes", core_rd_valid, 1'b1);
      step();
    end
    idle(); #1;

    // Reset while a core read is in flight.
    core_rd = 1; core_addr = 9'h1FF; step();
    core_rd = 0; reset = 1; #1;
    chk("t4 rv suppressed", core_rd_valid, 1'b0);
    chk("t4 core data zero", core_rd_data, '0);
    chk("t4 ext data zero", ext_rd_data, '0);
    step(); reset = 0; #1;
    chk("t4 after rst rv", core_rd_valid, 1'b0);
    core_rd = 1; core_addr = 9'h010; step(); core_rd = 0; #1;
    chk("t4 recover data", core_rd_data, 32'hDEADBEEF);
    idle();

    // Random traffic; the compare process checks every cycle.
    g = 0; s = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 199) == 0);
      if (!s) begin
        int r = $urandom_range(0, 3);
        core_rd = (r == 1 || r == 2); core_wr = (r == 3);
        core_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(504, 511));
        core_wr_data = $urandom;
      end
      if (ext_req && !g) begin
        if ($urandom_range(0, 15) == 0) ext_req = 0;
      end else begin
        ext_req = ($urandom_range(0, 2) == 0);
        ext_we = $urandom_range(0, 1);
        ext_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(504, 511));
        ext_wr_data = $urandom;
      end
      #1; g = ext_gnt; s = core_stall;
    end
    step(); idle(); repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port (512 words, 9-bit word address, 1-cycle read latency) between the core's load/store path and an external requester (debug/loader). Core has fixed priority. A starvation counter guarantees the external port a slot, and the core is stalled for that cycle. Sits between the Datapath memory interface (wr/rd/addr/wr_data/rd_data) and the data memory.

Parameters:
DATA_W, 32, data word width
ADDR_W, 9, word address width
STARVE_LIMIT, 4, consecutive cycles ext_req may be denied before the ext port is forced a grant (range 1..15)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
core_rd  in  1  core load request
core_wr  in  1  core store request
core_addr  in  ADDR_W  core address
core_wr_data  in  DATA_W  core store data
core_rd_data  out  DATA_W  load data returned to core
core_rd_valid  out  1  core_rd_data valid (one cycle after the grant)
core_stall  out  1  core access not performed this cycle; core must hold its request
ext_req  in  1  external access request, held until ext_gnt
ext_we  in  1  1 = write, 0 = read
ext_addr  in  ADDR_W  external address
ext_wr_data  in  DATA_W  external write data
ext_gnt  out  1  external access performed this cycle (combinational)
ext_rd_data  out  DATA_W  external read data
ext_rd_valid  out  1  ext_rd_data valid (one cycle after a read grant)
mem_wr  out  1  memory write strobe
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory address
mem_wr_data  out  DATA_W  memory write data
mem_rd_data  in  DATA_W  memory read data, valid the cycle after mem_rd

Behaviour:
- Reset: starve_cnt=0, owner tag=NONE, core_rd_valid=0, ext_rd_valid=0, core_rd_data=0, ext_rd_data=0.
- The grant decision is combinational from current requests and registered state.
- core_req = core_rd | core_wr. core_rd & core_wr together is illegal. The bench asserts on it; the RTL treats it as a write.
- Forced slot: force_ext = ext_req & (starve_cnt >= STARVE_LIMIT).
- Grant to ext when ext_req & (!core_req | force_ext). Otherwise grant to core when core_req. Otherwise idle, with mem_rd=mem_wr=0.
- core_stall = core_req & ext_gnt. ext_gnt = 1 only in a cycle in which the ext access drives the memory.
- Memory port muxes addr, wr_data and strobe from the granted side. All outputs are 0 when idle.
- starve_cnt:
  - reset to 0 on ext_gnt or !ext_req;
  - +1 when ext_req is denied;
  - saturates at 15.
- Owner tag register: {NONE, CORE, EXT}, set to the side granted a read, else NONE.
- Next cycle, mem_rd_data routes to the owner's rd_data, and that side's rd_valid=1 for exactly one cycle. The other side's rd_data holds its last value.
- Back-to-back reads from alternating owners must return correctly. The tag pipelines one deep, so throughput is 1 access/cycle.
- Write to the same address followed by a read on the next cycle returns the new data. The memory handles write-first; the arbiter adds no bypass.
- Reset asserted while a read is in flight: the pending rd_valid is suppressed and the tag is cleared.
- If ext_req drops without a grant, the counter clears and no access is made.
- States (2-bit FSM, registered): IDLE, CORE_RD_PEND, EXT_RD_PEND. Any state moves to the pending state of whichever side is granted a read this cycle, otherwise to IDLE. rd_valid is decoded from the state.

Decomposition:
- Package dmem_arb_pkg: owner_e enum {OWN_NONE, OWN_CORE, OWN_EXT}, and the default width constants DATA_W_DEF=32, ADDR_W_DEF=9.
- Sub-module starve_counter (saturating counter with clear/inc, compare output) is natural.
- Muxing and the FSM stay in the top.

Test Plan:
- Core-only traffic:
  - stimulus: core_wr addr 0x010 data 0xDEADBEEF, then core_rd 0x010;
  - response: no stall; core_rd_valid=1 one cycle after the read with 0xDEADBEEF; ext_rd_valid stays 0.
- Ext-only traffic:
  - stimulus: ext_req write 0x1FF=0x12345678, then a read;
  - response: ext_gnt same cycle as each request; ext_rd_valid next cycle with 0x12345678.
- Contention with starvation (STARVE_LIMIT=4):
  - stimulus: core_rd every cycle while ext_req is held;
  - response: ext denied 4 cycles, granted on the 5th, core_stall=1 that cycle only; the core request is serviced the following cycle.
- Alternating reads:
  - stimulus: core_rd A at cycle n, forced ext read B at n+1;
  - response: core_rd_valid at n+1 with mem[A], ext_rd_valid at n+2 with mem[B], no cross-routing.
- Idle core:
  - stimulus: ext_req with core idle;
  - response: immediate grant; starve_cnt stays 0.
- Reset mid-flight:
  - stimulus: core_rd granted, reset asserted next cycle;
  - response: core_rd_valid=0, all outputs at reset values, normal operation after reset deasserts.
